sram_ctr_ahb: RTL and testbench
===============================

Name: sram_ctr_ahb

Overview:
- AHB-Lite slave that bridges single-word AHB transfers to one single-port synchronous SRAM.
- SRAM size is 4K x 32.
- Always selected; there is no hsel input.
- Sits between the AHB master/interconnect and the SRAM macro, or the sram32 model in simulation.

Parameters:
- AW, 12, SRAM word-address width. sram_a is AW bits; the decoded window is 2^(AW+2) bytes.
- DW, 32, data width of the AHB data buses and the SRAM data buses.

Ports:
- hclk  in  1  system clock; all state changes on its rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hwrite  in  1  1 = write, 0 = read (address phase).
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hsize  in  3  transfer size; 0..2 legal, >2 errors.
- haddr  in  32  byte address.
- hburst  in  3  ignored; every beat carries its own address.
- hwdata  in  32  write data (data phase).
- hready  out  1  transfer done / slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  32  read data (data phase).
- sram_csn  out  1  SRAM chip select, active low.
- sram_wen  out  1  1 = write cycle, 0 = read cycle. The SRAM read enable is its inverse.
- sram_a  out  12  SRAM word address.
- sram_d  out  32  SRAM write data.
- sram_q  in  32  SRAM read data, registered inside the SRAM (1-cycle latency).

Behaviour:

Reset (async, hresetn=0):
- State returns to IDLE and the data-phase registers are cleared.
- hready=1, hresp=00, hrdata=0, sram_csn=1, sram_wen=0, sram_a=0, sram_d=0.

Address phase:
- An address phase is accepted only on a rising edge where hready=1 and htrans[1]=1. On acceptance, register hwrite, the word address haddr[13:2], and an error flag.
- The error flag is set when hsize>2 or haddr[31:14]!=0.
- haddr[1:0] is ignored.
- Sub-word writes store the whole hwdata word; masters issue word writes only.
- IDLE/BUSY transfers give a zero-wait OKAY and no SRAM access.

Write, zero wait:
- In the data-phase cycle: sram_csn=0, sram_wen=1, sram_a=registered address, sram_d=hwdata.
- hready=1, hresp=00.

Read, zero wait:
- The SRAM read is issued combinationally in the address-phase cycle: sram_csn=0, sram_wen=0, sram_a=haddr[13:2].
- In the next cycle (data phase): hrdata=sram_q, hready=1.
- Outside a read data phase, hrdata=0.

Read-after-write collision:
- Case: a read address phase coincides with a write data phase.
- The write owns the SRAM port. The read is registered as pending.
- Read data phase, cycle 1: hready=0, SRAM read issued from the registered address.
- Read data phase, cycle 2: hready=1, hrdata=sram_q.
- A read of the address just written returns the new data.

Error (two-cycle response):
- Cycle 1: hready=0, hresp=01.
- Cycle 2: hready=1, hresp=01.
- No SRAM access. The erroneous address phase does not issue the early read.

Idle SRAM:
- When no access is issued: sram_csn=1, sram_wen=0.
- sram_a and sram_d hold their last driven values.

State machine:
- States: IDLE, WR_DATA, RD_DATA, RD_STALL, ERR1, ERR2.
- Next state is chosen from the accepted address phase; RD_STALL→RD_DATA; ERR1→ERR2.
- From ERR2 the master may issue IDLE or a new transfer.
- Back-to-back NONSEQ/SEQ beats of any type run at full throughput, except the collision stall.

Reset mid-transfer: the pending operation is abandoned; no SRAM write occurs after reset asserts.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/ERROR.
  - SRAM_AW=12 and SRAM_DW=32.
  - The state enum.
- No sub-module is needed inside the controller.
- The SRAM is a separate module, sram32: 4096x32, synchronous write when cs_n=0 and w_en=1; registered dout updated when cs_n=0 and r_en=1; dout reset to 0.

Test Plan:
- Reset: hresetn=0 → hready=1, hresp=00, sram_csn=1, sram_wen=0, hrdata=0. Release hresetn with htrans=IDLE → no SRAM access.
- Write 0x11111111 to 0x0 and 0x22222222 to 0x4, back to back NONSEQ → data phases show sram_a=0 then 1, sram_wen=1, sram_d=hwdata, hready=1 throughout.
- Then read 0x4 after an IDLE cycle → read issued in the address phase; hrdata=0x22222222 in the next cycle, zero wait.
- Write 0x8=0xDEADBEEF immediately followed by read 0x8 → one hready=0 cycle, then hrdata=0xDEADBEEF, hresp=00.
- hsize=3, or haddr=0x00004000 → two-cycle ERROR (hready 0 then 1, hresp=01), sram_csn stays 1, memory unchanged.
- Assert hresetn=0 during a write data phase → sram_csn=1 immediately, location keeps its old value; hready=1 after reset.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, SRAM geometry and controller state type
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam int SRAM_AW = 12;
    localparam int SRAM_DW = 32;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_RD_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;
endpackage

// File: rtl/sram32.sv
// sram32: single-port synchronous SRAM with registered read data
module sram32
    import ahb_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_n,
    input  logic          w_en,
    input  logic          r_en,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (!cs_n && w_en) mem[a] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout <= '0;
        else if (!cs_n && r_en) dout <= mem[a];
endmodule

// File: rtl/sram_ctr_ahb.sv
// sram_ctr_ahb: AHB-Lite slave bridging single-word transfers to a synchronous single-port SRAM
module sram_ctr_ahb
    import ahb_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          hwrite,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic [31:0]   haddr,
    input  logic [2:0]    hburst,
    input  logic [DW-1:0] hwdata,
    output logic          hready,
    output logic [1:0]    hresp,
    output logic [DW-1:0] hrdata,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);
    state_t st, st_nx;
    logic [AW-1:0] a_q, a_last;
    logic [DW-1:0] d_last;
    logic acc, err_in, rd_early, use_a_q;
    logic unused_ok;
    assign unused_ok = ^{hburst, haddr[1:0], htrans[0]};
    assign acc = hresetn && hready && htrans[1];
    assign err_in = hsize > 3'd2 || |haddr[31:AW+2];
    // a read colliding with a write data phase loses the port and is replayed from a_q
    assign rd_early = acc && !hwrite && !err_in && st != ST_WR_DATA;
    assign use_a_q = st == ST_WR_DATA || st == ST_RD_STALL;
    always_comb
        st_nx = acc ? (err_in ? ST_ERR1 : hwrite ? ST_WR_DATA :
                       st == ST_WR_DATA ? ST_RD_STALL : ST_RD_DATA) :
                st == ST_RD_STALL ? ST_RD_DATA :
                st == ST_ERR1 ? ST_ERR2 : ST_IDLE;
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            st     <= ST_IDLE;
            a_q    <= '0;
            a_last <= '0;
            d_last <= '0;
        end else begin
            st     <= st_nx;
            a_last <= sram_a;
            d_last <= sram_d;
            if (acc) a_q <= haddr[AW+1:2];
        end
    assign hready = st != ST_RD_STALL && st != ST_ERR1;
    assign hresp = (st == ST_ERR1 || st == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata = st == ST_RD_DATA ? sram_q : '0;
    assign sram_csn = !(use_a_q || rd_early);
    assign sram_wen = st == ST_WR_DATA;
    assign sram_a = use_a_q ? a_q : rd_early ? haddr[AW+1:2] : a_last;
    assign sram_d = st == ST_WR_DATA ? hwdata : d_last;
endmodule

// File: tb/tb_sram_ctr_ahb.sv
// tb_sram_ctr_ahb: table-driven AHB master with scoreboard against sram_ctr_ahb + sram32
module tb_sram_ctr_ahb;
    import ahb_pkg::*;
    typedef struct {
        logic        idle;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;
    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;
    logic        hclk = 0, hresetn = 0, hwrite = 0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = 3'd2, hburst = 3'd0;
    logic [31:0] haddr = 0, hwdata = 0, hrdata, sram_d, sram_q;
    logic        hready, sram_csn, sram_wen;
    logic [1:0]  hresp;
    logic [11:0] sram_a;
    int n_cmp = 0, n_bad = 0, acc_cnt = 0, stall_cnt = 0;
    logic in_dp = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [43:0] wlog[$];
    vec_t tbl[8];
    always #5 hclk = ~hclk;
    sram_ctr_ahb dut (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
        .haddr(haddr), .hburst(hburst), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );
    sram32 mem (
        .clk(hclk), .rst_n(hresetn), .cs_n(sram_csn), .w_en(sram_wen), .r_en(~sram_wen),
        .a(sram_a), .din(sram_d), .dout(sram_q)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // data phases complete on the falling edge where hready=1 with a transfer outstanding
    always @(negedge hclk) begin
        if (!hresetn) begin
            sb.delete();
            in_dp = 0;
        end else begin
            if (!sram_csn) acc_cnt++;
            if (!sram_csn && sram_wen) wlog.push_back({sram_a, sram_d});
            if (!hready) stall_cnt++;
            if (in_dp) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else if (!hready) chk("hresp_wait", hresp, sb[0].err ? 2'b01 : 2'b00);
                else begin
                    mon_e = sb.pop_front();
                    chk("hresp", hresp, mon_e.err ? 2'b01 : 2'b00);
                    chk("hrdata", hrdata, mon_e.rd);
                end
            end
            if (hready) in_dp = htrans[1];
        end
    end
    task automatic xfer(input logic act, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic err);
        logic rdy;
        int n;
        htrans = act ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite = act && w;
        hsize = sz;
        haddr = a;
        if (act) sb.push_back('{err, rd});
        n = 0;
        do begin
            @(negedge hclk);
            rdy = hready;
            @(posedge hclk);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) chk("accept_timeout", 0, 1);
        if (act && w) hwdata = wd;
    endtask
    task automatic idle();
        xfer(0, 0, 3'd2, 0, 0, 0, 0);
    endtask
    initial begin
        int a0, s0, n0;
        tbl[0] = '{1, 0, 3'd2, 32'h4,    0,            32'h22222222};
        tbl[1] = '{0, 1, 3'd2, 32'hC,    32'hA5A5A5A5, 0};
        tbl[2] = '{1, 0, 3'd2, 32'h0,    0,            32'h11111111};
        tbl[3] = '{0, 0, 3'd2, 32'hC,    0,            32'hA5A5A5A5};
        tbl[4] = '{0, 0, 3'd1, 32'h6,    0,            32'h22222222};
        tbl[5] = '{0, 0, 3'd0, 32'h3,    0,            32'h11111111};
        tbl[6] = '{1, 1, 3'd0, 32'h3FFC, 32'h12345678, 0};
        tbl[7] = '{1, 0, 3'd2, 32'h3FFC, 0,            32'h12345678};
        #1;
        chk("rst_hready", hready, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_csn", sram_csn, 1);
        chk("rst_wen", sram_wen, 0);
        chk("rst_sram_a", sram_a, 0);
        chk("rst_sram_d", sram_d, 0);
        @(posedge hclk);
        @(posedge hclk);
        #1 hresetn = 1;
        a0 = acc_cnt;
        repeat (3) idle();
        chk("idle_no_access", acc_cnt - a0, 0);
        // back-to-back writes
        s0 = stall_cnt;
        n0 = wlog.size();
        xfer(1, 1, 3'd2, 32'h0, 32'h11111111, 0, 0);
        xfer(1, 1, 3'd2, 32'h4, 32'h22222222, 0, 0);
        idle();
        chk("wr_count", wlog.size() - n0, 2);
        chk("wr0_a_d", wlog[n0], {12'h000, 32'h11111111});
        chk("wr1_a_d", wlog[n0+1], {12'h001, 32'h22222222});
        chk("wr_no_stall", stall_cnt - s0, 0);
        s0 = stall_cnt;
        foreach (tbl[i]) begin
            if (tbl[i].idle) idle();
            xfer(1, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].rd, 0);
        end
        idle();
        chk("table_no_stall", stall_cnt - s0, 0);
        // write then read of the same word
        s0 = stall_cnt;
        xfer(1, 1, 3'd2, 32'h8, 32'hDEADBEEF, 0, 0);
        xfer(1, 0, 3'd2, 32'h8, 0, 32'hDEADBEEF, 0);
        idle();
        chk("raw_one_stall", stall_cnt - s0, 1);
        // two error beats back to back
        idle();
        a0 = acc_cnt;
        s0 = stall_cnt;
        xfer(1, 1, 3'd3, 32'hC, 32'hFFFFFFFF, 0, 1);
        xfer(1, 0, 3'd2, 32'h4000, 0, 0, 1);
        idle();
        idle();
        chk("err_no_access", acc_cnt - a0, 0);
        chk("err_stalls", stall_cnt - s0, 2);
        xfer(1, 0, 3'd2, 32'hC, 0, 32'hA5A5A5A5, 0);
        xfer(1, 1, 3'd2, 32'h80000000, 32'h0, 0, 1);
        idle();
        idle();
        // reset during a write data phase
        xfer(1, 1, 3'd2, 32'hC, 32'h99999999, 0, 0);
        #1;
        hresetn = 0;
        htrans = HTRANS_IDLE;
        hwrite = 0;
        #1;
        chk("rstmid_csn", sram_csn, 1);
        chk("rstmid_hready", hready, 1);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1;
        chk("post_rst_hready", hready, 1);
        idle();
        xfer(1, 0, 3'd2, 32'hC, 0, 32'hA5A5A5A5, 0);
        idle();
        idle();
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
